// File: rtl/nn_cfg_pkg.sv
// nn_cfg_pkg: shared config-stream header layout, opcodes and writer FSM types
package nn_cfg_pkg;
  localparam logic [3:0] CFG_OP_WLOAD = 4'hA;
  localparam int HDR_OP_LSB = 28;
  localparam int HDR_OP_W = 4;
  localparam int HDR_LAYER_LSB = 20;
  localparam int HDR_LAYER_W = 8;
  localparam int HDR_NEURON_LSB = 12;
  localparam int HDR_NEURON_W = 8;
  localparam int HDR_COUNT_LSB = 0;
  localparam int HDR_COUNT_W = 12;
  typedef enum logic [2:0] {IDLE, LOAD, SKIP, CHECK, DONE} wcw_state_t;
  typedef struct packed {
    logic [HDR_OP_W-1:0] op;
    logic [HDR_LAYER_W-1:0] layer;
    logic [HDR_NEURON_W-1:0] neuron;
    logic [HDR_COUNT_W-1:0] count;
  } wcw_hdr_t;
  function automatic wcw_hdr_t hdr_decode(input logic [31:0] w);
    return '{op: w[HDR_OP_LSB +: HDR_OP_W], layer: w[HDR_LAYER_LSB +: HDR_LAYER_W],
             neuron: w[HDR_NEURON_LSB +: HDR_NEURON_W], count: w[HDR_COUNT_LSB +: HDR_COUNT_W]};
  endfunction
endpackage

// File: rtl/wcw_checksum.sv
// wcw_checksum: 16-bit running sum of weight words, compared against a trailer word
module wcw_checksum (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        add,
  input  logic [15:0] din,
  input  logic [15:0] ref_sum,
  output logic        match
);
  logic [15:0] sum;
  // restart on each new header, accumulate mod 2^16 on each written weight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sum <= '0;
    else sum <= clr ? '0 : add ? sum + din : sum;
  assign match = sum == ref_sum;
endmodule

// File: rtl/weight_config_writer.sv
// weight_config_writer: decodes the layer config stream into per-neuron weight memory writes (optional trailer checksum: WCW_CHECKSUM_EN)
module weight_config_writer
  import nn_cfg_pkg::*;
#(
  parameter int DATA_BITS    = 16,
  parameter int NUM_WEIGHTS  = 784,
  parameter int ADDRESS_BITS = 10,
  parameter int LAYER_NO     = 0,
  parameter int NUM_NEURONS  = 30,
  parameter int NEURON_BITS  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [31:0]             cfg_data,
  output logic [NUM_NEURONS-1:0]  wr_en,
  output logic [ADDRESS_BITS-1:0] wr_addr,
  output logic [DATA_BITS-1:0]    wr_data,
  output logic                    load_done,
  output logic                    cfg_err
);
  localparam logic [7:0] LAYER_ID = 8'(LAYER_NO);
  localparam logic [7:0] NEURON_LIM = 8'(NUM_NEURONS);
  localparam logic [11:0] MAX_CNT = 12'(NUM_WEIGHTS);
  wcw_state_t state, state_nx;
  wcw_hdr_t hdr;
  logic hs, hs_idle, hs_load, op_ok, layer_hit, bad_rng, sum_ok, err_set;
  logic [NEURON_BITS-1:0] neuron_q;
  logic [ADDRESS_BITS-1:0] addr;
  logic [11:0] remaining;
  logic [12:0] skip_cnt, skip_len;
`ifdef WCW_CHECKSUM_EN
  localparam logic [12:0] TRAILER = 13'd1;
  localparam wcw_state_t LAST_ST = CHECK;
  wcw_checksum u_checksum (
    .clk(clk), .rst_n(rst_n), .clr(hs_idle), .add(hs_load),
    .din(cfg_data[15:0]), .ref_sum(cfg_data[15:0]), .match(sum_ok)
  );
`else
  localparam logic [12:0] TRAILER = 13'd0;
  localparam wcw_state_t LAST_ST = DONE;
  assign sum_ok = 1'b0;
`endif
  assign hdr = hdr_decode(cfg_data);
  assign cfg_ready = rst_n && state != DONE;
  assign hs = cfg_valid && cfg_ready;
  assign hs_idle = hs && state == IDLE;
  assign hs_load = hs && state == LOAD;
  assign op_ok = hdr.op == CFG_OP_WLOAD;
  assign layer_hit = hdr.layer == LAYER_ID;
  assign bad_rng = hdr.neuron >= NEURON_LIM || hdr.count > MAX_CNT;
  assign skip_len = {1'b0, hdr.count} + TRAILER;
  assign err_set = (hs_idle && (!op_ok || (layer_hit && bad_rng))) || (hs && state == CHECK && !sum_ok);
  // next-state decode: header classification in IDLE, beat counting elsewhere
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (hs && op_ok) state_nx = (!layer_hit || bad_rng) ? (skip_len == '0 ? IDLE : SKIP)
                                        : hdr.count == '0 ? DONE : LOAD;
      LOAD:  if (hs && remaining == 12'd1) state_nx = LAST_ST;
      SKIP:  if (hs && skip_cnt == 13'd1) state_nx = IDLE;
      CHECK: if (hs) state_nx = sum_ok ? DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // header latching, address/beat counters and registered memory write port
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      neuron_q <= '0;
      addr <= '0;
      remaining <= '0;
      skip_cnt <= '0;
      wr_en <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      load_done <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      wr_en <= hs_load ? NUM_NEURONS'(1) << neuron_q : '0;
      wr_addr <= hs_load ? addr : wr_addr;
      wr_data <= hs_load ? cfg_data[DATA_BITS-1:0] : wr_data;
      neuron_q <= hs_idle ? hdr.neuron[NEURON_BITS-1:0] : neuron_q;
      addr <= hs_idle ? '0 : hs_load ? addr + 1'b1 : addr;
      remaining <= hs_idle ? hdr.count : hs_load ? remaining - 1'b1 : remaining;
      skip_cnt <= hs_idle ? skip_len : (hs && state == SKIP) ? skip_cnt - 1'b1 : skip_cnt;
      load_done <= state == DONE;
      cfg_err <= err_set ? 1'b1 : (hs_idle && op_ok) ? 1'b0 : cfg_err;
    end
endmodule

// File: tb/tb_weight_config_writer.sv
// tb_weight_config_writer: randomized scoreboard bench for weight_config_writer
module tb_weight_config_writer;
  localparam int NN = 30;
  localparam int NW = 784;
  localparam int LAYER = 0;
`ifdef WCW_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  typedef struct {int n; int a; logic [15:0] d;} wr_t;
  typedef struct {int nwr; bit timed;} done_t;
  logic clk = 0, rst_n = 0, cfg_valid = 0, cfg_ready, load_done, cfg_err;
  logic [31:0] cfg_data = '0;
  logic [NN-1:0] wr_en;
  logic [9:0] wr_addr;
  logic [15:0] wr_data;
  wr_t wq[$];
  done_t dq[$];
  logic [31:0] words[$];
  int checks = 0, errors = 0, cyc = 0, wr_seen = 0, last_wr = -10, pushed = 0;
  bit err_m = 0;
  wr_t e;
  done_t de;
  logic [NN-1:0] exp_en;

  weight_config_writer #(.DATA_BITS(16), .NUM_WEIGHTS(NW), .ADDRESS_BITS(10), .LAYER_NO(LAYER),
    .NUM_NEURONS(NN), .NEURON_BITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .load_done(load_done), .cfg_err(cfg_err));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  // scoreboard monitor: pops expected writes/done pulses as the DUT presents them
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (wr_en != '0) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write en=%h addr=%0d data=%h required=none", wr_en, wr_addr, wr_data);
        end else begin
          e = wq.pop_front();
          exp_en = '0;
          exp_en[e.n] = 1'b1;
          if (wr_en !== exp_en || wr_addr !== 10'(e.a) || wr_data !== e.d) begin
            errors++;
            $display("FAIL write en=%h addr=%0d data=%h required en=%h addr=%0d data=%h",
                     wr_en, wr_addr, wr_data, exp_en, e.a, e.d);
          end
        end
        wr_seen++;
        last_wr = cyc;
      end
      if (load_done) begin
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_load_done at cycle %0d required=none", cyc);
        end else begin
          de = dq.pop_front();
          if (wr_seen != de.nwr || (de.timed && cyc != last_wr + 1)) begin
            errors++;
            $display("FAIL load_done writes=%0d gap=%0d required writes=%0d gap=1",
                     wr_seen, cyc - last_wr, de.nwr);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    cfg_valid = 1;
    cfg_data = w;
    while (!cfg_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", cfg_ready, 1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    cfg_valid = 0;
  endtask

  // reference model: classify header by the stream rules, predict writes/done/err, drive beats
  task automatic txn(input logic [3:0] op, input int layer, input int neuron, input int count,
                     input bit gap, input bit good_trl, input int abort_at);
    int nwords;
    bit load = 0;
    logic [15:0] sum = '0;
    logic [31:0] w;
    if (op != 4'hA) begin err_m = 1; nwords = 0; end
    else if (layer != LAYER) begin err_m = 0; nwords = count + CK; end
    else if (neuron >= NN || count > NW) begin err_m = 1; nwords = count + CK; end
    else begin err_m = 0; nwords = count; load = 1; end
    send({op, 8'(layer), 8'(neuron), 12'(count)});
    for (int i = 0; i < nwords; i++) begin
      if (i == abort_at) begin
        idle();
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        chk("rst_wq_drained", wq.size(), 0);
        err_m = 0;
        return;
      end
      w = i < words.size() ? words[i] : $urandom;
      if (load) begin
        wq.push_back('{neuron, i, w[15:0]});
        pushed++;
        sum += w[15:0];
      end
      send(w);
      if (gap) idle();
    end
    if (load) begin
      if (count == 0) dq.push_back('{pushed, 0});
      else if (CK == 0) dq.push_back('{pushed, 1});
      else begin
        send(good_trl ? {16'h0, sum} : {16'h0, sum ^ 16'h1});
        if (good_trl) dq.push_back('{pushed, 0});
        else err_m = 1;
      end
    end
    idle();
    repeat (3) @(negedge clk);
    chk("cfg_err", cfg_err, err_m);
  endtask

  initial begin
    #1;
    chk("reset_wr_en", wr_en, 0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_load_done", load_done, 0);
    chk("reset_cfg_err", cfg_err, 0);
    chk("reset_cfg_ready", cfg_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1 chk("ready_after_reset", cfg_ready, 1);
    words = '{32'h0011, 32'h0022, 32'h0033, 32'h0044};
    txn(4'hA, LAYER, 3, 4, 0, 1, -1);
    words = '{};
    txn(4'hA, LAYER + 1, 0, 5, 0, 1, -1);
    txn(4'hA, LAYER, NN, 2, 0, 1, -1);
    txn(4'hA, LAYER, 0, NW + 1, 0, 1, -1);
    txn(4'hA, LAYER, NN - 1, 2, 0, 1, -1);
    txn(4'h5, LAYER, 1, 1, 0, 1, -1);
    txn(4'hA, LAYER, 2, 0, 0, 1, -1);
    txn(4'hA, LAYER, 5, 3, 1, 1, -1);
    txn(4'hA, LAYER, 7, 6, 0, 1, 2);
    txn(4'hA, LAYER, 7, 3, 0, 1, -1);
    words = '{32'hFFFF, 32'h0002};
    txn(4'hA, LAYER, 9, 2, 0, 1, -1);
    txn(4'hA, LAYER, 9, 2, 0, 0, -1);
    words = '{};
    for (int k = 0; k < 30; k++)
      txn(($urandom % 8 == 0) ? 4'h3 : 4'hA, ($urandom % 4 == 0) ? LAYER + 1 : LAYER,
          $urandom_range(0, NN + 3), $urandom_range(0, 10), 1'($urandom % 2), 1'($urandom % 4 != 0), -1);
    chk("wq_empty", wq.size(), 0);
    chk("dq_empty", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
